// File: rtl/kd_tree_pkg.sv
// Shared constants and state encoding for the internal-node loader.
package kd_tree_pkg;

  localparam int DSIZE       = 11;  // node word width (one signed field)
  localparam int FETCH_WIDTH = 2;   // aggregator group size / pad target (1..7)
  localparam int CNT_WIDTH   = 9;   // word counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAD   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/internal_node_loader_if.sv
// Host stream (valid/ready) and SyncFIFO write port bundled for the loader.
// slave = loader side, master = host/FIFO environment side.
interface internal_node_loader_if;
  import kd_tree_pkg::*;

  logic             in_valid;
  logic [DSIZE-1:0] in_data;
  logic             in_ready;
  logic             fifo_full_n;
  logic             fifo_enq;
  logic [DSIZE-1:0] fifo_wdata;

  modport slave (
    input  in_valid, in_data, fifo_full_n,
    output in_ready, fifo_enq, fifo_wdata
  );

  modport master (
    output in_valid, in_data, fifo_full_n,
    input  in_ready, fifo_enq, fifo_wdata
  );

endinterface

// File: rtl/skid_buffer2.sv
// Two-entry in-order buffer. Entry 0 is the head; empty entries are held at
// zero so the head register reads 0 whenever the buffer is empty.
module skid_buffer2
  import kd_tree_pkg::*;
(
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DSIZE-1:0] din_i,
  output logic [DSIZE-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [DSIZE-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_pop_s, do_push_s;

  assign do_pop_s  = pop_i && (occ_q != 2'd0);
  assign do_push_s = push_i && ((occ_q != 2'd2) || do_pop_s);

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({do_push_s, do_pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_d = din_i;
        end else begin
          e1_d = din_i;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        e1_d  = '0;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = din_i;
        end else begin
          e0_d = e1_q;
          e1_d = din_i;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Entry and occupancy registers with synchronous active-low reset.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head_o = e0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/internal_node_loader.sv
// Write-side producer for the internal-node SyncFIFO: accepts num_words host
// words, zero-pads to a FETCH_WIDTH multiple, and enqueues through a 2-entry
// skid buffer so host acceptance never depends combinationally on FIFO space.
module internal_node_loader
  import kd_tree_pkg::*;
(
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  internal_node_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_count
);

  loader_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, acc_q, wc_q;
  logic [2:0]           mod_q;   // (accepted + pads) mod FETCH_WIDTH
  logic [1:0]           occ_s;
  logic [DSIZE-1:0]     head_s, push_data_s;
  logic                 in_ready_s, xfer_s, pad_push_s, push_s, pop_s;

  // Acceptance uses only registered state so FIFO backpressure is decoupled.
  assign in_ready_s  = (state_q == LOAD) && (occ_s != 2'd2) && (acc_q < num_q);
  assign xfer_s      = bus.in_valid && in_ready_s;
  assign pad_push_s  = (state_q == PAD) && (mod_q != 3'd0) && (occ_s != 2'd2);
  assign push_s      = xfer_s || pad_push_s;
  assign push_data_s = xfer_s ? bus.in_data : {DSIZE{1'b0}};
  assign pop_s       = (occ_s != 2'd0) && bus.fifo_full_n;

  skid_buffer2 u_skid (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .push_i (push_s),
    .pop_i  (pop_s),
    .din_i  (push_data_s),
    .head_o (head_s),
    .occ_o  (occ_s)
  );

  // Load sequencing: accept, pad to group boundary, drain, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
        else       state_d = IDLE;
      end
      LOAD: begin
        if ((acc_q == num_q) || (xfer_s && ((acc_q + CNT_WIDTH'(1)) == num_q))) state_d = PAD;
        else state_d = LOAD;
      end
      PAD: begin
        if (mod_q == 3'd0) state_d = DRAIN;
        else               state_d = PAD;
      end
      DRAIN: begin
        if ((occ_s == 2'd0) || ((occ_s == 2'd1) && pop_s)) state_d = DONE;
        else state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, load length, accepted/enqueued counters and pad phase tracker.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      wc_q    <= '0;
      mod_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        num_q <= num_words;
        acc_q <= '0;
        wc_q  <= '0;
        mod_q <= 3'd0;
      end else begin
        if (xfer_s) acc_q <= acc_q + CNT_WIDTH'(1);
        if (pop_s)  wc_q  <= wc_q + CNT_WIDTH'(1);
        if (push_s) mod_q <= (mod_q == 3'(FETCH_WIDTH - 1)) ? 3'd0 : mod_q + 3'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.fifo_enq   = pop_s;
  assign bus.fifo_wdata = head_s;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign word_count     = wc_q;

endmodule
